// File: rtl/ledsched_pkg.sv
// Shared types and helpers for the LED strip frame scheduler.
// Optional build macro handled by the top: LEDSCHED_BRIGHTNESS_EN.
package ledsched_pkg;

  localparam int RGB_W = 24;
  localparam int CH_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_PIX,
    S_WAIT_READY,
    S_WAIT_STARTED,
    S_DONE
  } sched_state_e;

  // Each GRB channel is shifted on its own so no bits bleed between colours.
  function automatic logic [RGB_W-1:0] dim_pixel(input logic [RGB_W-1:0] pix,
                                                 input logic [2:0]       shift);
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] b;
    g = pix[23:16] >> shift;
    r = pix[15:8]  >> shift;
    b = pix[7:0]   >> shift;
    return {g, r, b};
  endfunction

endpackage

// File: rtl/ledstrip_refresh_timer.sv
// Free-running refresh counter plus a single pending flag that collects
// periodic ticks and on-demand requests until the scheduler consumes them.
module ledstrip_refresh_timer
  import ledsched_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic frame_req_i,
  input  logic clear_i,
  output logic pending_o
);

  logic [REFRESH_BITS-1:0] cnt_q;
  logic [REFRESH_BITS-1:0] cnt_d;
  logic                    pending_q;
  logic                    pending_d;
  logic                    tick;

  assign tick  = &cnt_q;
  assign cnt_d = cnt_q + 1'b1;

  // Consumption wins over a coinciding event: the frame starting now serves it.
  always_comb begin
    pending_d = pending_q;
    if (clear_i) begin
      pending_d = 1'b0;
    end else if (tick || frame_req_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/ledstrip_frame_sched.sv
// Frame scheduler: walks LED indices, fetches pixels and hands them to the
// WS2812B driver. Optional macro: LEDSCHED_BRIGHTNESS_EN (per-channel dimming).
module ledstrip_frame_sched
  import ledsched_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int LED_W        = 9,
  parameter int PIX_LAT      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LED_W-1:0] num_leds,
  input  logic             frame_req,
  input  logic [2:0]       brightness,
  output logic [LED_W-1:0] pix_index,
  output logic             pix_req,
  input  logic [23:0]      pix_data,
  output logic [23:0]      drv_data,
  output logic             drv_valid,
  output logic             drv_latch,
  input  logic             drv_ready,
  output logic             busy,
  output logic             frame_done
);

  // Driver handshake: drv_valid rises only while drv_ready is high, then is
  // held until drv_ready is observed low (the driver has taken the pixel).
  localparam logic [1:0] LAT_LAST = 2'(PIX_LAT - 1);

  sched_state_e     state_q, state_d;
  logic [LED_W-1:0] idx_q, idx_d;
  logic [LED_W-1:0] n_lat_q, n_lat_d;
  logic [1:0]       lat_cnt_q, lat_cnt_d;
  logic [LED_W-1:0] pix_index_q, pix_index_d;
  logic             pix_req_q, pix_req_d;
  logic [23:0]      drv_data_q, drv_data_d;
  logic             drv_valid_q, drv_valid_d;
  logic             drv_latch_q, drv_latch_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             pending;
  logic             pend_clear;
  logic             is_last;
  logic [23:0]      pix_scaled;

`ifdef LEDSCHED_BRIGHTNESS_EN
  assign pix_scaled = dim_pixel(pix_data, brightness);
`else
  logic [2:0] unused_brightness;
  assign unused_brightness = brightness;
  assign pix_scaled        = pix_data;
`endif

  ledstrip_refresh_timer #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .frame_req_i(frame_req),
    .clear_i    (pend_clear),
    .pending_o  (pending)
  );

  assign is_last = (idx_q == n_lat_q - 1'b1);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_lat_d      = n_lat_q;
    lat_cnt_d    = lat_cnt_q;
    pix_index_d  = pix_index_q;
    pix_req_d    = 1'b0;
    drv_data_d   = drv_data_q;
    drv_valid_d  = drv_valid_q;
    drv_latch_d  = drv_latch_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    pend_clear   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pending) begin
          pend_clear = 1'b1;
          n_lat_d    = num_leds;
          idx_d      = '0;
          if (num_leds == '0) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d     = S_FETCH;
            busy_d      = 1'b1;
            pix_req_d   = 1'b1;
            pix_index_d = '0;
          end
        end
      end
      S_FETCH: begin
        lat_cnt_d = '0;
        state_d   = S_WAIT_PIX;
      end
      S_WAIT_PIX: begin
        if (lat_cnt_q == LAT_LAST) begin
          drv_data_d = pix_scaled;
          state_d    = S_WAIT_READY;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      S_WAIT_READY: begin
        if (drv_ready) begin
          drv_valid_d = 1'b1;
          drv_latch_d = is_last;
          state_d     = S_WAIT_STARTED;
        end
      end
      S_WAIT_STARTED: begin
        if (!drv_ready) begin
          drv_valid_d = 1'b0;
          drv_latch_d = 1'b0;
          if (is_last) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end else begin
            idx_d       = idx_q + 1'b1;
            pix_index_d = idx_q + 1'b1;
            pix_req_d   = 1'b1;
            state_d     = S_FETCH;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      n_lat_q      <= '0;
      lat_cnt_q    <= '0;
      pix_index_q  <= '0;
      pix_req_q    <= 1'b0;
      drv_data_q   <= '0;
      drv_valid_q  <= 1'b0;
      drv_latch_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_lat_q      <= n_lat_d;
      lat_cnt_q    <= lat_cnt_d;
      pix_index_q  <= pix_index_d;
      pix_req_q    <= pix_req_d;
      drv_data_q   <= drv_data_d;
      drv_valid_q  <= drv_valid_d;
      drv_latch_q  <= drv_latch_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_index  = pix_index_q;
  assign pix_req    = pix_req_q;
  assign drv_data   = drv_data_q;
  assign drv_valid  = drv_valid_q;
  assign drv_latch  = drv_latch_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ledstrip_frame_sched.sv
// Self-checking bench for ledstrip_frame_sched: table-driven frames with a
// transfer scoreboard, plus sequences for collapse, stalls, reset and refresh.
module tb_ledstrip_frame_sched;

`ifdef LEDSCHED_BRIGHTNESS_EN
  localparam bit BRIGHT_EN = 1'b1;
`else
  localparam bit BRIGHT_EN = 1'b0;
`endif
  localparam logic [23:0] EXP_OVR = BRIGHT_EN ? 24'h3F2010 : 24'hFF8040;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic [8:0]  num_leds;
  logic        frame_req;
  logic [2:0]  brightness;
  logic [8:0]  pix_index;
  logic        pix_req;
  logic [23:0] pix_data;
  logic [23:0] drv_data;
  logic        drv_valid;
  logic        drv_latch;
  logic        drv_ready;
  logic        busy;
  logic        frame_done;

  logic [8:0]  pix_index_b;
  logic        pix_req_b;
  logic [23:0] drv_data_b;
  logic        drv_valid_b;
  logic        drv_latch_b;
  logic        drv_ready_b;
  logic        busy_b;
  logic        frame_done_b;

  ledstrip_frame_sched #(.REFRESH_BITS(18), .LED_W(9), .PIX_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .num_leds(num_leds), .frame_req(frame_req),
    .brightness(brightness), .pix_index(pix_index), .pix_req(pix_req),
    .pix_data(pix_data), .drv_data(drv_data), .drv_valid(drv_valid),
    .drv_latch(drv_latch), .drv_ready(drv_ready), .busy(busy),
    .frame_done(frame_done)
  );

  ledstrip_frame_sched #(.REFRESH_BITS(4), .LED_W(9), .PIX_LAT(1)) dut_r4 (
    .clk(clk), .rst_n(rst_n), .num_leds(9'd1), .frame_req(1'b0),
    .brightness(3'd0), .pix_index(pix_index_b), .pix_req(pix_req_b),
    .pix_data(24'h0), .drv_data(drv_data_b), .drv_valid(drv_valid_b),
    .drv_latch(drv_latch_b), .drv_ready(drv_ready_b), .busy(busy_b),
    .frame_done(frame_done_b)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [24:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] src_pix(input logic [8:0] idx);
    logic [23:0] base;
    base = 24'h010203;
    return base * (24'(idx) + 24'd1);
  endfunction

  function automatic logic [23:0] exp_pix(input logic [23:0] p, input logic [2:0] b);
    logic [7:0] g, r, bl;
    g  = p[23:16] >> b;
    r  = p[15:8] >> b;
    bl = p[7:0] >> b;
    return BRIGHT_EN ? {g, r, bl} : p;
  endfunction

  // ---------------- pixel source model (latency 1) ----------------
  logic        src_ovr_en;
  logic [23:0] src_override;
  always @(posedge clk) begin
    if (pix_req) pix_data <= src_ovr_en ? src_override : src_pix(pix_index);
    else         pix_data <= 24'hA5A5A5 ^ 24'(cyc);
  end

  // ---------------- driver models ----------------
  logic model_ready = 1'b1;
  logic drv_auto;
  logic drv_force;
  int   vcnt = 0;
  int   lowcnt = 0;
  assign drv_ready = drv_auto ? model_ready : drv_force;

  // Accepts a pixel two cycles after valid is seen, stays busy for three.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_ready = 1'b1;
      vcnt = 0;
      lowcnt = 0;
    end else if (!model_ready) begin
      lowcnt++;
      if (lowcnt >= 3) model_ready = 1'b1;
    end else if (drv_valid && drv_auto) begin
      vcnt++;
      if (vcnt == 2) begin
        logic [24:0] e;
        model_ready = 1'b0;
        vcnt = 0;
        lowcnt = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", {7'd0, drv_latch, drv_data}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("transfer_data_latch", {7'd0, drv_latch, drv_data}, {7'd0, e});
        end
      end
    end
  end

  logic ready_b_q = 1'b1;
  assign drv_ready_b = ready_b_q;
  always @(negedge clk) ready_b_q = !drv_valid_b;

  // ---------------- monitors ----------------
  int   preq_cnt = 0, done_cnt = 0, vrise_cnt = 0;
  logic busy_prev = 1'b0, valid_prev = 1'b0, busy_b_prev = 1'b0;
  int   done_cyc_q[$];
  int   rise_cyc_q[$];
  int   rise_b_q[$];
  always @(posedge clk) begin
    #1;
    if (pix_req) preq_cnt++;
    if (frame_done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
    end
    if (busy && !busy_prev) rise_cyc_q.push_back(cyc);
    if (drv_valid && !valid_prev) vrise_cnt++;
    if (busy_b && !busy_b_prev) rise_b_q.push_back(cyc);
    busy_prev   = busy;
    valid_prev  = drv_valid;
    busy_b_prev = busy_b;
  end

  // ---------------- stimulus tasks ----------------
  int req_cyc;
  task automatic pulse_req();
    @(negedge clk);
    frame_req = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_count", done_cnt, target);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pix_req"}, pix_req, 0);
    check({tag, "_pix_index"}, pix_index, 0);
    check({tag, "_drv_valid"}, drv_valid, 0);
    check({tag, "_drv_latch"}, drv_latch, 0);
    check({tag, "_drv_data"}, drv_data, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [8:0]  n;
    logic [2:0]  bright;
    logic        ovr_en;
    logic [23:0] ovr;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vec_t v;
    int   preq0, vr0, d0, r0, d_first;
    logic [23:0] e;

    rst_n = 1'b0; num_leds = 9'd0; frame_req = 1'b0; brightness = 3'd0;
    src_ovr_en = 1'b0; src_override = 24'h0; drv_auto = 1'b1; drv_force = 1'b0;

    vecs[0] = '{n: 9'd3, bright: 3'd0, ovr_en: 1'b0, ovr: 24'h0};
    vecs[1] = '{n: 9'd1, bright: 3'd0, ovr_en: 1'b0, ovr: 24'h0};
    vecs[2] = '{n: 9'd5, bright: 3'd1, ovr_en: 1'b0, ovr: 24'h0};
    vecs[3] = '{n: 9'd2, bright: 3'd7, ovr_en: 1'b0, ovr: 24'h0};
    vecs[4] = '{n: 9'd1, bright: 3'd2, ovr_en: 1'b1, ovr: 24'hFF8040};
    vecs[5] = '{n: 9'd0, bright: 3'd0, ovr_en: 1'b0, ovr: 24'h0};

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    check("reset_no_pix_req", preq_cnt, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      num_leds = v.n; brightness = v.bright;
      src_ovr_en = v.ovr_en; src_override = v.ovr;
      preq0 = preq_cnt; vr0 = vrise_cnt; d0 = done_cnt;
      for (int k = 0; k < int'(v.n); k++) begin
        e = v.ovr_en ? EXP_OVR : exp_pix(src_pix(9'(k)), v.bright);
        exp_q.push_back({(k == int'(v.n) - 1), e});
      end
      pulse_req();
      @(negedge clk);
      if (v.n != 0) num_leds = 9'd50;
      wait_done(d0 + 1, 400);
      if (v.n == 0) check("empty_done_latency_le2", (done_cyc_q[$] - req_cyc) <= 2, 1);
      check("pix_req_count", preq_cnt - preq0, 32'(v.n));
      check("valid_rise_count", vrise_cnt - vr0, 32'(v.n));
      check("scoreboard_drained", exp_q.size(), 0);
      @(negedge clk);
      check("busy_low_after_done", busy, 0);
      check("frame_done_single", frame_done, 0);
      repeat (4) @(negedge clk);
    end
    src_ovr_en = 1'b0; brightness = 3'd0;

    // Two requests during a frame collapse into exactly one further frame.
    num_leds = 9'd3;
    preq0 = preq_cnt; d0 = done_cnt; r0 = rise_cyc_q.size();
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 3; k++) exp_q.push_back({(k == 2), src_pix(9'(k))});
    pulse_req();
    repeat (4) @(negedge clk);
    pulse_req();
    repeat (3) @(negedge clk);
    pulse_req();
    wait_done(d0 + 1, 400);
    d_first = done_cyc_q[$];
    wait_done(d0 + 2, 400);
    repeat (60) @(negedge clk);
    check("collapse_frames", done_cnt - d0, 2);
    check("collapse_busy_rises", rise_cyc_q.size() - r0, 2);
    check("collapse_restart_gap", rise_cyc_q[$] - d_first, 2);
    check("collapse_pix_reqs", preq_cnt - preq0, 6);
    check("collapse_scoreboard", exp_q.size(), 0);

    // Driver never ready: scheduler parks with valid low, then reset mid-frame.
    drv_auto = 1'b0; drv_force = 1'b0;
    num_leds = 9'd2;
    preq0 = preq_cnt; vr0 = vrise_cnt; d0 = done_cnt;
    pulse_req();
    repeat (100) @(negedge clk);
    check("stall_no_valid", vrise_cnt - vr0, 0);
    check("stall_busy", busy, 1);
    check("stall_one_fetch", preq_cnt - preq0, 1);
    check("stall_captured", drv_data, src_pix(9'd0));
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    check("midreset_no_done", done_cnt - d0, 0);
    @(negedge clk);
    rst_n = 1'b1; drv_auto = 1'b1;

    // Periodic refresh on the 4-bit timer instance.
    repeat (110) @(negedge clk);
    check("r4_enough_frames", rise_b_q.size() >= 5, 1);
    if (rise_b_q.size() >= 5) begin
      for (int j = 1; j <= 3; j++)
        check("r4_period", rise_b_q[rise_b_q.size() - j] - rise_b_q[rise_b_q.size() - j - 1], 16);
    end
    check("main_idle_at_end", busy, 0);
    check("final_scoreboard", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
